// File: rtl/tag_req_sequencer.sv
// Tag request sequencer: issues one fresh request plus reuse requests per block,
// then flushes the cache, waits for all tags to drain and signals layer completion.
module tag_req_sequencer #(
    parameter int NUM_TAGS = 2,
    parameter int TAG_W    = $clog2(NUM_TAGS),
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_num_blocks,
    input  logic [CNT_W-1:0] cfg_reuse_count,
    input  logic             cfg_bias_prev_sw,
    input  logic             cfg_ddr_pe_sw,
    output logic             busy,
    output logic             done,
    output logic             tag_req,
    output logic             tag_reuse,
    output logic             tag_bias_prev_sw,
    output logic             tag_ddr_pe_sw,
    output logic             block_done,
    input  logic             tag_ready,
    input  logic [TAG_W-1:0] tag,
    input  logic             tag_done,
    output logic             issued_valid,
    output logic [TAG_W-1:0] issued_tag
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] blk_idx, req_idx;
    logic [CNT_W-1:0] num_blocks_q, reuse_count_q;
    logic             bias_prev_sw_q, ddr_pe_sw_q;
    logic             accept, last_req, last_blk;

    always_comb begin
        accept   = (state == S_REQ) && tag_ready;
        last_req = (req_idx == reuse_count_q);
        last_blk = (blk_idx == num_blocks_q - CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (cfg_num_blocks == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (accept && last_req && last_blk) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (tag_done) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Configuration is only sampled in IDLE, so a start pulse mid-layer cannot disturb it.
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_idx        <= '0;
            req_idx        <= '0;
            num_blocks_q   <= '0;
            reuse_count_q  <= '0;
            bias_prev_sw_q <= 1'b0;
            ddr_pe_sw_q    <= 1'b0;
            issued_valid   <= 1'b0;
            issued_tag     <= '0;
        end else begin
            issued_valid <= accept;
            if (accept) begin
                issued_tag <= tag;
            end
            if (state == S_IDLE && start) begin
                num_blocks_q   <= cfg_num_blocks;
                reuse_count_q  <= cfg_reuse_count;
                bias_prev_sw_q <= cfg_bias_prev_sw;
                ddr_pe_sw_q    <= cfg_ddr_pe_sw;
                blk_idx        <= '0;
                req_idx        <= '0;
            end else if (accept) begin
                if (last_req) begin
                    req_idx <= '0;
                    blk_idx <= blk_idx + CNT_W'(1);
                end else begin
                    req_idx <= req_idx + CNT_W'(1);
                end
            end
        end
    end

    // The very first request of a layer has no previous partial sum to accumulate onto.
    always_comb begin
        busy             = (state != S_IDLE);
        done             = (state == S_DONE);
        block_done       = (state == S_FLUSH);
        tag_req          = 1'b0;
        tag_reuse        = 1'b0;
        tag_bias_prev_sw = 1'b0;
        tag_ddr_pe_sw    = 1'b0;
        if (state == S_REQ) begin
            tag_req          = 1'b1;
            tag_reuse        = (req_idx != '0);
            tag_bias_prev_sw = bias_prev_sw_q && !((blk_idx == '0) && (req_idx == '0));
            tag_ddr_pe_sw    = ddr_pe_sw_q;
        end
    end

endmodule

// File: doc/tag_req_sequencer.md
Name: tag_req_sequencer

Overview:
Front-end controller for the double-buffer tag synchroniser. For one layer it generates the tag request stream: one fresh-tag request per block, followed by a configurable number of reuse requests, with per-request switch flags. After the last block it issues the cache flush (`block_done`), waits for all tags to drain, and signals layer completion. It sits between the layer-level control FSM and the tag synchroniser.

Parameters:
- NUM_TAGS, 2, number of buffer tags in the downstream tag synchroniser.
- TAG_W, $clog2(NUM_TAGS), tag index width.
- CNT_W, 16, width of the block and reuse counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches config and starts the layer.
- cfg_num_blocks  in  CNT_W  number of blocks in the layer.
- cfg_reuse_count  in  CNT_W  reuse requests per block after the fresh request.
- cfg_bias_prev_sw  in  1  bias/previous-sum select for non-first requests.
- cfg_ddr_pe_sw  in  1  store-path select, applied to all requests.
- busy  out  1  high from accepted start until the done pulse, inclusive.
- done  out  1  one-cycle layer-complete pulse.
- tag_req  out  1  tag request to the synchroniser.
- tag_reuse  out  1  the request reuses the previous tag.
- tag_bias_prev_sw  out  1  bias/prev switch sent with the request.
- tag_ddr_pe_sw  out  1  store-path switch sent with the request.
- block_done  out  1  one-cycle cache-flush pulse.
- tag_ready  in  1  synchroniser can accept the request.
- tag  in  TAG_W  tag granted for the current request.
- tag_done  in  1  all tags free.
- issued_valid  out  1  one-cycle pulse per accepted request.
- issued_tag  out  TAG_W  tag captured at acceptance; holds until the next acceptance.

Behaviour:
- States: IDLE, REQ, FLUSH, DRAIN, DONE. Reset forces IDLE and zeroes all counters and registered outputs.
- Reset values: every output is 0, including issued_tag.
- IDLE:
  - On start, latch all cfg_* inputs and clear blk_idx and req_idx.
  - If cfg_num_blocks==0, go to DONE; otherwise go to REQ.
  - start is ignored in every state except IDLE.
- REQ:
  - tag_req=1.
  - tag_reuse=(req_idx!=0).
  - tag_ddr_pe_sw = latched ddr_pe_sw.
  - tag_bias_prev_sw = latched bias_prev_sw, except it is forced 0 when blk_idx==0 and req_idx==0.
  - All of these outputs are combinational from state and counters and are stable while waiting on tag_ready.
- Acceptance occurs on a cycle where tag_req && tag_ready. On that edge:
  - issued_valid is pulsed the following cycle (registered).
  - issued_tag <= tag.
  - If req_idx==latched reuse_count: req_idx<=0 and blk_idx<=blk_idx+1. If blk_idx==num_blocks-1, go to FLUSH.
  - Otherwise req_idx<=req_idx+1.
- Requests per block = reuse_count+1. Counters never wrap within a layer; the all-ones reuse_count is legal.
- FLUSH: block_done=1 for exactly one cycle, then go to DRAIN. tag_req=0 in FLUSH, DRAIN and DONE.
- DRAIN: wait for tag_done=1, then go to DONE. tag_done high on the first DRAIN cycle moves to DONE on the next edge.
- DONE: done=1 for one cycle, then go to IDLE. busy=0 from the following cycle.
- Latency:
  - start to first tag_req: 1 cycle.
  - Final acceptance to block_done: 1 cycle.
  - tag_done to done: 1 cycle (from DRAIN).
- tag_ready low holds REQ indefinitely with no counter change.
- Reset asserted mid-layer (any state) returns to IDLE on the next edge. No block_done or done is generated.

Test Plan:
- num_blocks=3, reuse=0, tag_ready=1, synchroniser tags alternating → 3 accepts, all with tag_reuse=0; issued_tag 0,1,0; block_done one cycle after the third accept; done 1 cycle after tag_done.
- num_blocks=2, reuse=2 → 6 requests with tag_reuse pattern 0,1,1,0,1,1; bias_prev_sw pattern (cfg=1) 0,1,1,1,1,1; ddr_pe_sw matches cfg throughout.
- tag_ready low for 5 cycles mid-block → tag_req and flags stable; no counter change or issued_valid until tag_ready rises.
- num_blocks=0 → done pulses 1 cycle after start; no tag_req and no block_done.
- start re-pulsed while busy, then reset asserted in REQ after 1 accept → second start ignored; outputs zero the cycle after reset; next start runs a full layer cleanly.
- tag_done held low for 20 cycles in DRAIN → busy stays 1 and done does not assert; tag_done=1 → done pulses exactly once.
